// File: rtl/tx_frame_arbiter_if.sv
// tx_frame_arbiter_if
//   Bundles the two source FIFO read ports (A and B) and the MAC tx FIFO write
//   port that the frame arbiter sits between.
//   Handshake: a source byte is consumed on a rising clk edge where its rden=1
//   (the FIFO is first-word-fall-through, so dout/sof show the head before the
//   pop); a tx byte is accepted on a rising edge where txff_wr=1, and the
//   arbiter only raises txff_wr while txff_full=0.
//   Modports:
//     master - the arbiter: reads source heads, drives rden and tx writes
//     slave  - the environment: source FIFOs and the MAC tx FIFO
interface tx_frame_arbiter_if;
  logic [7:0] a_dout;
  logic       a_sof;
  logic       a_empty;
  logic       a_rden;
  logic [7:0] b_dout;
  logic       b_sof;
  logic       b_empty;
  logic       b_rden;
  logic [7:0] txff_din;
  logic       txff_wr_sof;
  logic       txff_wr;
  logic       txff_full;

  modport master (
    input  a_dout, a_sof, a_empty,
    output a_rden,
    input  b_dout, b_sof, b_empty,
    output b_rden,
    output txff_din, txff_wr_sof, txff_wr,
    input  txff_full
  );

  modport slave (
    output a_dout, a_sof, a_empty,
    input  a_rden,
    output b_dout, b_sof, b_empty,
    input  b_rden,
    input  txff_din, txff_wr_sof, txff_wr,
    output txff_full
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//   Shares the MAC tx FIFO write port between two framed sources, A and B.
//   Each frame is a 2-byte big-endian size header (sof on the first byte)
//   followed by size bytes. Whole frames are granted, the size is checked,
//   legal frames are copied, illegal ones are drained, and frames cut short
//   by an early sof are padded with zeros to their declared size.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     jumboframes    selects MAX_JUMBO as the upper size limit
//     bus            source A/B read ports and tx FIFO write port
//     grant          one-hot owner (01 = A, 10 = B), 0 when idle
//     drop_count     frames discarded for illegal size (wraps)
//     sync_count     stray bytes discarded plus truncated frames (wraps)
//     state_dbg      current FSM state
module tx_frame_arbiter #(
  parameter bit PRIO_A    = 1'b0,
  parameter int MIN_SIZE  = 14,
  parameter int MAX_STD   = 1514,
  parameter int MAX_JUMBO = 9014
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 jumboframes,
  tx_frame_arbiter_if.master   bus,
  output logic [1:0]           grant,
  output logic [15:0]          drop_count,
  output logic [15:0]          sync_count,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    IDLE, SZ_LO, CHECK, OUT_HI, OUT_LO, FWD, PAD, DROP, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        sel;       // owner of the current frame: 1 = B
  logic        rr_last;   // last served source: 1 = B
  logic [15:0] size;
  logic [13:0] cnt;

  // Head of the granted source
  logic [7:0] cur_dout;
  logic       cur_sof, cur_empty;
  assign cur_dout  = sel ? bus.b_dout  : bus.a_dout;
  assign cur_sof   = sel ? bus.b_sof   : bus.a_sof;
  assign cur_empty = sel ? bus.b_empty : bus.a_empty;

  logic a_req, b_req, win_b;
  assign a_req = !bus.a_empty && bus.a_sof;
  assign b_req = !bus.b_empty && bus.b_sof;
  // B wins if A is not asking, or on a tie in round-robin mode when A was served last
  assign win_b = b_req && (!a_req || (!PRIO_A && !rr_last));

  logic [15:0] limit, cnt_p1;
  logic        size_ok, last_byte;
  assign limit     = jumboframes ? 16'(MAX_JUMBO) : 16'(MAX_STD);
  assign size_ok   = (size >= 16'(MIN_SIZE)) && (size <= limit);
  assign cnt_p1    = {2'b00, cnt} + 16'd1;
  assign last_byte = (cnt_p1 == size);

  logic       a_pop, b_pop, pop_cur, wr, wsof;
  logic [7:0] din;
  logic       take, load_lo, cnt_clr, cnt_inc, drop_inc, done;
  logic [1:0] sync_inc;

  always_comb begin
    state_nxt = state;
    a_pop     = 1'b0;
    b_pop     = 1'b0;
    pop_cur   = 1'b0;
    wr        = 1'b0;
    wsof      = 1'b0;
    din       = 8'h00;
    take      = 1'b0;
    load_lo   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    drop_inc  = 1'b0;
    done      = 1'b0;
    sync_inc  = 2'd0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          take      = 1'b1;
          a_pop     = !win_b;
          b_pop     = win_b;
          state_nxt = SZ_LO;
        end
        // A non-sof head while idle belongs to no frame: discard it
        if (!bus.a_empty && !bus.a_sof) begin
          a_pop    = 1'b1;
          sync_inc = sync_inc + 2'd1;
        end
        if (!bus.b_empty && !bus.b_sof) begin
          b_pop    = 1'b1;
          sync_inc = sync_inc + 2'd1;
        end
      end
      SZ_LO: begin
        if (!cur_empty) begin
          pop_cur   = 1'b1;
          load_lo   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        cnt_clr = 1'b1;
        if (size_ok) begin
          state_nxt = OUT_HI;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = DROP;
        end
      end
      OUT_HI: begin
        if (!bus.txff_full) begin
          wr        = 1'b1;
          wsof      = 1'b1;
          din       = size[15:8];
          state_nxt = OUT_LO;
        end
      end
      OUT_LO: begin
        if (!bus.txff_full) begin
          wr        = 1'b1;
          din       = size[7:0];
          state_nxt = (size == 16'd0) ? DONE : FWD;
        end
      end
      FWD: begin
        if (!cur_empty) begin
          if (cur_sof) begin
            // Next frame already started: leave its sof in place, pad this one
            sync_inc  = 2'd1;
            state_nxt = PAD;
          end else if (!bus.txff_full) begin
            pop_cur = 1'b1;
            wr      = 1'b1;
            din     = cur_dout;
            cnt_inc = 1'b1;
            if (last_byte) state_nxt = DONE;
          end
        end
      end
      PAD: begin
        if (!bus.txff_full) begin
          wr      = 1'b1;
          din     = 8'h00;
          cnt_inc = 1'b1;
          if (last_byte) state_nxt = DONE;
        end
      end
      DROP: begin
        if (!cur_empty) begin
          if (cur_sof) begin
            state_nxt = DONE;
          end else begin
            pop_cur = 1'b1;
            cnt_inc = 1'b1;
            if (last_byte) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      rr_last    <= 1'b0;
      grant      <= 2'b00;
      size       <= 16'd0;
      cnt        <= 14'd0;
      drop_count <= 16'd0;
      sync_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        sel        <= win_b;
        grant      <= win_b ? 2'b10 : 2'b01;
        size[15:8] <= win_b ? bus.b_dout : bus.a_dout;
      end
      if (load_lo) size[7:0] <= cur_dout;
      if (cnt_clr)      cnt <= 14'd0;
      else if (cnt_inc) cnt <= cnt + 14'd1;
      if (drop_inc) drop_count <= drop_count + 16'd1;
      sync_count <= sync_count + {14'd0, sync_inc};
      if (done) begin
        rr_last <= sel;
        grant   <= 2'b00;
      end
    end
  end

  // Strobes are held low for the whole time reset is asserted
  assign bus.a_rden      = reset_n & (a_pop | (pop_cur & ~sel));
  assign bus.b_rden      = reset_n & (b_pop | (pop_cur & sel));
  assign bus.txff_wr     = reset_n & wr;
  assign bus.txff_wr_sof = reset_n & wsof;
  assign bus.txff_din    = din;
  assign state_dbg       = state;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic jumboframes;

  tx_frame_arbiter_if ifc ();
  tx_frame_arbiter_if ifp ();

  logic [1:0]  grant_c, grant_p;
  logic [15:0] drop_c, drop_p, sync_c, sync_p;
  logic [3:0]  st_c, st_p;

  // Round-robin instance
  tx_frame_arbiter #(.PRIO_A(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .jumboframes(jumboframes), .bus(ifc.master),
    .grant(grant_c), .drop_count(drop_c), .sync_count(sync_c), .state_dbg(st_c)
  );

  // Strict-priority instance, fed the same source heads
  tx_frame_arbiter #(.PRIO_A(1'b1)) dut_p (
    .clk(clk), .reset_n(reset_n), .jumboframes(jumboframes), .bus(ifp.master),
    .grant(grant_p), .drop_count(drop_p), .sync_count(sync_p), .state_dbg(st_p)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int   checks = 0;
  int   errors = 0;
  bit   use_p = 1'b0;        // which instance the source/tx models follow
  bit   full_toggle = 1'b0;
  int   cyc = 0;
  int   sof_pop_cyc = 0;
  int   lat = -1;
  logic [1:0] cur_g = 2'b00;

  logic [8:0] a_q[$];        // {sof, byte} source contents
  logic [8:0] b_q[$];
  logic [8:0] exp_q[$];      // expected tx FIFO writes {sof, byte}
  logic [1:0] exp_g_q[$];    // expected grant per forwarded frame

  logic [1:0]  grant_s;
  logic [15:0] drop_s, sync_s;
  logic [3:0]  st_s;
  assign grant_s = use_p ? grant_p : grant_c;
  assign drop_s  = use_p ? drop_p  : drop_c;
  assign sync_s  = use_p ? sync_p  : sync_c;
  assign st_s    = use_p ? st_p    : st_c;

  localparam logic [3:0] ST_IDLE = 4'd0;

  // ---------------- source and tx FIFO models ----------------
  task automatic drive_heads();
    logic [8:0] h;
    logic ae, be;
    ae = (a_q.size() == 0);
    be = (b_q.size() == 0);
    h = ae ? 9'h000 : a_q[0];
    ifc.a_empty = ae; ifp.a_empty = ae;
    ifc.a_dout = h[7:0]; ifp.a_dout = h[7:0];
    ifc.a_sof = h[8]; ifp.a_sof = h[8];
    h = be ? 9'h000 : b_q[0];
    ifc.b_empty = be; ifp.b_empty = be;
    ifc.b_dout = h[7:0]; ifp.b_dout = h[7:0];
    ifc.b_sof = h[8]; ifp.b_sof = h[8];
  endtask

  initial begin : env
    logic [8:0] h;
    logic s_ar, s_br, s_wr, s_wsof, fv;
    logic [7:0] s_din;
    logic [1:0] s_grant;
    fv = 1'b0;
    ifc.txff_full = 1'b0;
    ifp.txff_full = 1'b0;
    drive_heads();
    forever begin
      @(negedge clk);
      s_ar    = use_p ? ifp.a_rden : ifc.a_rden;
      s_br    = use_p ? ifp.b_rden : ifc.b_rden;
      s_wr    = use_p ? ifp.txff_wr : ifc.txff_wr;
      s_wsof  = use_p ? ifp.txff_wr_sof : ifc.txff_wr_sof;
      s_din   = use_p ? ifp.txff_din : ifc.txff_din;
      s_grant = grant_s;
      @(posedge clk);
      #1;
      cyc++;
      if (s_ar) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_a_empty: a_rden=1 with source A empty");
        end else begin
          h = a_q.pop_front();
          if (h[8]) sof_pop_cyc = cyc;
        end
      end
      if (s_br) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_b_empty: b_rden=1 with source B empty");
        end else begin
          h = b_q.pop_front();
          if (h[8]) sof_pop_cyc = cyc;
        end
      end
      if (s_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: wrote sof=%0b byte=%02h, required no write", s_wsof, s_din);
        end else begin
          h = exp_q.pop_front();
          if ({s_wsof, s_din} !== h)
            begin errors++; $display("FAIL tx_byte: got sof=%0b byte=%02h, required sof=%0b byte=%02h", s_wsof, s_din, h[8], h[7:0]); end
        end
        if (s_wsof) begin
          lat = cyc - sof_pop_cyc;
          cur_g = (exp_g_q.size() != 0) ? exp_g_q.pop_front() : 2'b00;
        end
        checks++;
        if (s_grant !== cur_g) begin
          errors++;
          $display("FAIL grant_during_frame: got %b, required %b", s_grant, cur_g);
        end
      end
      fv = full_toggle ? !fv : 1'b0;
      ifc.txff_full = fv;
      ifp.txff_full = fv;
      drive_heads();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_src(input bit src_b, input logic [8:0] w);
    if (src_b) b_q.push_back(w);
    else       a_q.push_back(w);
  endtask

  task automatic load_frame(input bit src_b, input int size, input int npay, input int base);
    logic [15:0] s;
    s = 16'(size);
    push_src(src_b, {1'b1, s[15:8]});
    push_src(src_b, {1'b0, s[7:0]});
    for (int i = 0; i < npay; i++) push_src(src_b, {1'b0, 8'(base + i)});
  endtask

  // Scoreboard prediction: header, payload present, zero padding up to size
  task automatic expect_frame(input bit src_b, input int size, input int npay, input int base);
    logic [15:0] s;
    s = 16'(size);
    exp_q.push_back({1'b1, s[15:8]});
    exp_q.push_back({1'b0, s[7:0]});
    for (int i = 0; i < size; i++)
      exp_q.push_back((i < npay) ? {1'b0, 8'(base + i)} : 9'h000);
    exp_g_q.push_back(src_b ? 2'b10 : 2'b01);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: left exp=%0d a=%0d b=%0d after %0d cycles, required all 0",
               name, exp_q.size(), a_q.size(), b_q.size(), budget);
      exp_q.delete(); exp_g_q.delete(); a_q.delete(); b_q.delete();
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    a_q.delete(); b_q.delete(); exp_q.delete(); exp_g_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    jumboframes = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (grant_c !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b, required 00", grant_c); end
    checks++; if (drop_c !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d, required 0", drop_c); end
    checks++; if (sync_c !== 16'd0) begin errors++; $display("FAIL rst_sync: got %0d, required 0", sync_c); end
    checks++; if (st_c !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required 0", st_c); end
    checks++; if ({ifc.a_rden, ifc.b_rden, ifc.txff_wr} !== 3'b000)
      begin errors++; $display("FAIL rst_strobes: got %b, required 000", {ifc.a_rden, ifc.b_rden, ifc.txff_wr}); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (st_c !== ST_IDLE || grant_c !== 2'b00)
      begin errors++; $display("FAIL rst_release: state=%0d grant=%b, required 0/00", st_c, grant_c); end
  endtask

  task automatic test_single_a();
    lat = -1;
    load_frame(1'b0, 60, 60, 1);
    expect_frame(1'b0, 60, 60, 1);
    wait_drain("single_a", 500);
    checks++; if (lat != 3) begin errors++; $display("FAIL single_a_latency: got %0d, required 3", lat); end
    checks++; if (grant_c !== 2'b00) begin errors++; $display("FAIL single_a_grant_idle: got %b, required 00", grant_c); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) begin
      load_frame(1'b0, 20, 20, 1 + 20 * k);
      load_frame(1'b1, 20, 20, 8'h80 + 20 * k);
    end
    // A was served last, so B takes the first tie and they alternate
    for (int k = 0; k < 4; k++) begin
      expect_frame(1'b1, 20, 20, 8'h80 + 20 * k);
      expect_frame(1'b0, 20, 20, 1 + 20 * k);
    end
    wait_drain("round_robin", 1000);
  endtask

  task automatic test_size_limits();
    logic [15:0] d0;
    d0 = drop_s;
    jumboframes = 1'b0;
    load_frame(1'b0, 1520, 1520, 0);
    wait_drain("drop_1520", 3000);
    checks++; if (drop_s !== 16'(d0 + 1)) begin errors++; $display("FAIL drop_1520_std: got %0d, required %0d", drop_s, d0 + 1); end
    jumboframes = 1'b1;
    load_frame(1'b0, 1520, 1520, 7);
    expect_frame(1'b0, 1520, 1520, 7);
    wait_drain("fwd_1520_jumbo", 3000);
    checks++; if (drop_s !== 16'(d0 + 1)) begin errors++; $display("FAIL fwd_1520_jumbo_drop: got %0d, required %0d", drop_s, d0 + 1); end
    jumboframes = 1'b0;
    load_frame(1'b0, 8, 8, 3);
    wait_drain("drop_8", 100);
    checks++; if (drop_s !== 16'(d0 + 2)) begin errors++; $display("FAIL drop_8: got %0d, required %0d", drop_s, d0 + 2); end
    load_frame(1'b0, 14, 14, 8'h31);
    load_frame(1'b0, 13, 13, 8'h41);
    load_frame(1'b0, 1514, 1514, 8'h51);
    load_frame(1'b0, 1515, 1515, 8'h61);
    expect_frame(1'b0, 14, 14, 8'h31);
    expect_frame(1'b0, 1514, 1514, 8'h51);
    wait_drain("bounds", 6000);
    checks++; if (drop_s !== 16'(d0 + 4)) begin errors++; $display("FAIL bounds_drop: got %0d, required %0d", drop_s, d0 + 4); end
  endtask

  task automatic test_early_sof();
    logic [15:0] s0;
    s0 = sync_s;
    load_frame(1'b0, 30, 10, 8'h40);
    load_frame(1'b0, 20, 20, 8'h60);
    expect_frame(1'b0, 30, 10, 8'h40);
    expect_frame(1'b0, 20, 20, 8'h60);
    wait_drain("early_sof", 500);
    checks++; if (sync_s !== 16'(s0 + 1)) begin errors++; $display("FAIL early_sof_sync: got %0d, required %0d", sync_s, s0 + 1); end
  endtask

  task automatic test_stray_and_backpressure();
    logic [15:0] s0;
    s0 = sync_s;
    for (int i = 0; i < 3; i++) a_q.push_back({1'b0, 8'(8'hE0 + $urandom_range(0, 15))});
    load_frame(1'b0, 60, 60, 8'hA0);
    expect_frame(1'b0, 60, 60, 8'hA0);
    full_toggle = 1'b1;
    wait_drain("backpressure", 1000);
    full_toggle = 1'b0;
    checks++; if (sync_s !== 16'(s0 + 3)) begin errors++; $display("FAIL stray_sync: got %0d, required %0d", sync_s, s0 + 3); end
  endtask

  task automatic test_mid_frame_reset();
    int n;
    load_frame(1'b0, 60, 60, 8'h20);
    expect_frame(1'b0, 60, 60, 8'h20);
    n = 0;
    while (exp_q.size() > 30 && n < 200) begin @(posedge clk); #2; n++; end
    checks++; if (exp_q.size() > 30) begin errors++; $display("FAIL midrst_progress: %0d writes pending, required <= 30", exp_q.size()); end
    @(posedge clk); #2;
    checks++; if (ifc.txff_wr !== 1'b1) begin errors++; $display("FAIL midrst_active: txff_wr=%b, required 1", ifc.txff_wr); end
    reset_n = 1'b0;
    #1;
    checks++; if ({ifc.a_rden, ifc.txff_wr} !== 2'b00)
      begin errors++; $display("FAIL midrst_strobes: got %b, required 00", {ifc.a_rden, ifc.txff_wr}); end
    checks++; if (grant_c !== 2'b00 || st_c !== ST_IDLE)
      begin errors++; $display("FAIL midrst_state: grant=%b state=%0d, required 00/0", grant_c, st_c); end
    a_q.delete(); b_q.delete(); exp_q.delete(); exp_g_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (st_c !== ST_IDLE || sync_c !== 16'd0 || drop_c !== 16'd0)
      begin errors++; $display("FAIL midrst_release: state=%0d sync=%0d drop=%0d, required 0/0/0", st_c, sync_c, drop_c); end
  endtask

  task automatic test_back_to_back();
    // Pointer was cleared by reset: B wins the first tie
    load_frame(1'b0, 16, 16, 8'h30);
    load_frame(1'b1, 16, 16, 8'hB0);
    expect_frame(1'b1, 16, 16, 8'hB0);
    expect_frame(1'b0, 16, 16, 8'h30);
    wait_drain("back_to_back", 300);
  endtask

  task automatic test_priority();
    use_p = 1'b1;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      load_frame(1'b0, 20, 20, 1 + 20 * k);
      load_frame(1'b1, 20, 20, 8'h80 + 20 * k);
    end
    for (int k = 0; k < 4; k++) expect_frame(1'b0, 20, 20, 1 + 20 * k);
    for (int k = 0; k < 4; k++) expect_frame(1'b1, 20, 20, 8'h80 + 20 * k);
    wait_drain("priority", 1000);
    checks++; if (grant_s !== 2'b00) begin errors++; $display("FAIL priority_idle_grant: got %b, required 00", grant_s); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_size_limits();
    test_early_sof();
    test_stray_and_backpressure();
    test_mid_frame_reset();
    test_back_to_back();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the MAC transmit FIFO write port between two frame sources, A and B. Typical sources are the video streamer and the control/UDP responder.
- Each source is a first-word-fall-through FIFO that holds framed bytes: a two-byte big-endian size header, flagged by sof on its first byte, followed by frame bytes.
- Arbitration is per whole frame. Granted frames are validated and copied to the tx FIFO, so the transmit engine only sees well-formed, non-interleaved frames.

Parameters:
- PRIO_A, 0, 0 = round-robin between A and B; 1 = A has strict priority.
- MIN_SIZE, 14, smallest legal size field value.
- MAX_STD, 1514, largest legal size when jumboframes=0.
- MAX_JUMBO, 9014, largest legal size when jumboframes=1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jumboframes  in  1  selects MAX_JUMBO as the size limit
- a_dout  in  8  source A head byte
- a_sof  in  1  source A head byte is a frame start
- a_empty  in  1  source A FIFO empty
- a_rden  out  1  pop source A head
- b_dout, b_sof, b_empty, b_rden  same as the A ports, for source B
- txff_din  out  8  byte to the MAC tx FIFO
- txff_wr_sof  out  1  start-of-frame flag written alongside txff_din
- txff_wr  out  1  write strobe
- txff_full  in  1  MAC tx FIFO full
- grant  out  2  one-hot current owner; 0 when idle
- drop_count  out  16  frames discarded for illegal size
- sync_count  out  16  out-of-sync bytes discarded plus truncated frames

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State=IDLE; grant, drop_count, sync_count and the round-robin pointer all reset to 0.
  - Pointer 0 means A was last served, so B wins the first tie.
  - a_rden, b_rden and txff_wr are forced 0 while reset_n is low.
  - Deasserting reset mid-frame restarts in IDLE; there is no recovery of a partial frame.
- Handshake:
  - Pops and writes are combinational from the current state and the empty/full inputs.
  - A byte moves only in a cycle with src rden=1 and txff_wr=1, and txff_wr=1 implies txff_full=0.
- Size field: number of frame bytes that follow the two header bytes, excluding FCS. The forwarded frame is size+2 bytes.
- States:
  - IDLE:
    - A source requests when !empty & sof.
    - Winner: PRIO_A=1 → A if it requests; otherwise round-robin favours the source not last served.
    - The winner's byte 0 is popped into size[15:8] in the same cycle, grant is set, and the next state is SZ_LO.
    - A non-requesting source with !empty & !sof has its byte popped and discarded; sync_count increments by 1 per such source (+2 if both).
  - SZ_LO: when the source is !empty, pop into size[7:0] and go to CHECK. Wait while empty.
  - CHECK (one cycle):
    - Legal when MIN_SIZE ≤ size ≤ limit, where limit = jumboframes ? MAX_JUMBO : MAX_STD.
    - Legal → OUT_HI. Illegal → DROP, and drop_count increments.
    - Compare on the full 16 bits; the 14-bit byte counter is cleared.
  - OUT_HI: when !txff_full, write size[15:8] with txff_wr_sof=1, then go to OUT_LO.
  - OUT_LO: when !txff_full, write size[7:0], then go to FWD (or straight to DONE if size==0; unreachable while MIN_SIZE>0).
  - FWD:
    - Each cycle with !empty & !sof & !txff_full: pop and write one byte, count+1.
    - When count reaches size, go to DONE.
    - Source empty or txff_full → stall; the tx FIFO is not written.
  - Early SOF in FWD:
    - Trigger: the source head is !empty & sof before count reaches size.
    - The head byte is not popped and sync_count increments (+1).
    - Next state is PAD.
  - PAD: writes 0x00 for each remaining byte (when !txff_full) until count reaches size, then goes to DONE.
  - DROP: pops and discards size bytes, treating the source like FWD but with txff_wr=0. An early sof ends DROP without popping and without incrementing sync_count.
  - DONE (one cycle): update the round-robin pointer to the served source, clear grant, go to IDLE.
- Counters: drop_count and sync_count are 16-bit and wrap; the byte counter is 14-bit.
- Latency: the first tx FIFO write comes 3 cycles after the IDLE grant cycle when neither side stalls. Steady-state throughput in FWD is 1 byte/cycle.
- txff_din is a don't-care when txff_wr=0.

Test Plan:
- A only, size=0x003C, bytes 1..60, no stalls → tx FIFO receives 00 3C (sof on first) then 1..60; first write 3 cycles after grant; grant=01 throughout.
- A and B both request with the same size=20, PRIO_A=0, repeated 4 frames each → grants alternate B,A,B,A…; no interleaving; 8 frames written intact.
- Same as above with PRIO_A=1 → all A frames go first, then B; B is never granted while A requests.
- Size=0x05F0 (1520): jumboframes=0 → drop_count=1, nothing written, 1520 bytes popped; jumboframes=1 → frame forwarded; size=8 → dropped.
- size=30, source sof appears after 10 payload bytes → 10 bytes forwarded then 20×0x00; sync_count=1; the next frame starts cleanly from that sof.
- Stray non-sof bytes 3 in A while idle, plus txff_full toggled every other cycle during a 60-byte frame → sync_count=3; no byte lost or duplicated; reset_n pulsed low mid-FWD → outputs 0 immediately; IDLE after release.
